// File: rtl/text_overlay_pkg.sv
// Shared definitions for the text overlay generators.
//   mode_e      : overlay animation mode encodings
//   LOGO_BITMAP : default team logo, row r / column c at bit r*LOGO_W + c
//                 (column 0 is the LSB of each row and is drawn leftmost)
//   clog2_min1  : $clog2 that never returns 0, for sizing counters/indices
package text_overlay_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC       = 2'b00,
        MODE_SCROLL       = 2'b01,
        MODE_BLINK        = 2'b10,
        MODE_SCROLL_BLINK = 2'b11
    } mode_e;

    localparam int unsigned LOGO_W = 60;
    localparam int unsigned LOGO_H = 10;

    // Rows listed bottom (row 9) to top (row 0); each row is 60 bits.
    localparam logic [LOGO_W*LOGO_H-1:0] LOGO_BITMAP = {
        60'hFFFFFFFFFFFFFFF,
        60'h800000000000001,
        60'h8A5A5A5A5A5A5A1,
        60'h8A5A5A5A5A5A5A1,
        60'h8C3C3C3C3C3C3C1,
        60'h8C3C3C3C3C3C3C1,
        60'h8A5A5A5A5A5A5A1,
        60'h8A5A5A5A5A5A5A1,
        60'h800000000000001,
        60'hFFFFFFFFFFFFFFF
    };

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/text_marquee_timer.sv
// Frame-rate dividers for the text marquee.
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   i_frame_start  : one-cycle pulse per frame
//   i_enable       : overlay enable; low clears all divider state
//   i_mode         : animation mode (bit 0 scroll, bit 1 blink)
//   o_scroll_pos   : current scroll offset in cells, 0..BMP_W-1
//   o_blink_off    : high during the dark half of the blink period
module text_marquee_timer
    import text_overlay_pkg::*;
#(
    parameter int unsigned BMP_W      = 60,
    parameter int unsigned SCROLL_DIV = 2,
    parameter int unsigned BLINK_DIV  = 30
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_frame_start,
    input  logic                            i_enable,
    input  logic [1:0]                      i_mode,
    output logic [clog2_min1(BMP_W)-1:0]    o_scroll_pos,
    output logic                            o_blink_off
);

    localparam int unsigned PW = clog2_min1(BMP_W);
    localparam int unsigned SW = clog2_min1(SCROLL_DIV);
    localparam int unsigned BW = clog2_min1(BLINK_DIV);

    logic [SW-1:0] r_scroll_cnt, w_scroll_cnt_nxt;
    logic [PW-1:0] r_scroll_pos, w_scroll_pos_nxt;
    logic [BW-1:0] r_blink_cnt,  w_blink_cnt_nxt;
    logic          r_blink_off,  w_blink_off_nxt;

    logic w_scroll_en;
    logic w_blink_en;

    assign w_scroll_en = (i_mode == MODE_SCROLL) || (i_mode == MODE_SCROLL_BLINK);
    assign w_blink_en  = (i_mode == MODE_BLINK)  || (i_mode == MODE_SCROLL_BLINK);

    always_comb begin
        w_scroll_cnt_nxt = r_scroll_cnt;
        w_scroll_pos_nxt = r_scroll_pos;
        w_blink_cnt_nxt  = r_blink_cnt;
        w_blink_off_nxt  = r_blink_off;
        if (!i_enable) begin
            // Clear wins over a coincident frame strobe.
            w_scroll_cnt_nxt = '0;
            w_scroll_pos_nxt = '0;
            w_blink_cnt_nxt  = '0;
            w_blink_off_nxt  = 1'b0;
        end else if (i_frame_start) begin
            if (w_scroll_en) begin
                if (r_scroll_cnt == SW'(SCROLL_DIV - 1)) begin
                    w_scroll_cnt_nxt = '0;
                    w_scroll_pos_nxt = (r_scroll_pos == PW'(BMP_W - 1)) ? '0
                                                                       : r_scroll_pos + 1'b1;
                end else begin
                    w_scroll_cnt_nxt = r_scroll_cnt + 1'b1;
                end
            end
            if (w_blink_en) begin
                if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                    w_blink_cnt_nxt = '0;
                    w_blink_off_nxt = ~r_blink_off;
                end else begin
                    w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scroll_cnt <= '0;
            r_scroll_pos <= '0;
            r_blink_cnt  <= '0;
            r_blink_off  <= 1'b0;
        end else begin
            r_scroll_cnt <= w_scroll_cnt_nxt;
            r_scroll_pos <= w_scroll_pos_nxt;
            r_blink_cnt  <= w_blink_cnt_nxt;
            r_blink_off  <= w_blink_off_nxt;
        end
    end

    assign o_scroll_pos = r_scroll_pos;
    assign o_blink_off  = r_blink_off;

endmodule

// File: rtl/text_marquee.sv
// Registered bitmap text overlay with optional horizontal scroll and blink.
//   clk, rst_n         : pixel clock, asynchronous active-low reset
//   i_x, i_y           : live pixel counters
//   i_frame_start      : one-cycle pulse per frame
//   i_enable           : overlay enable
//   i_mode             : 00 static, 01 scroll, 10 blink, 11 scroll+blink
//   o_overlay_active   : pixel-on, one cycle after x/y are sampled
module text_marquee
    import text_overlay_pkg::*;
#(
    parameter int unsigned                BMP_W      = LOGO_W,
    parameter int unsigned                BMP_H      = LOGO_H,
    parameter logic [BMP_W*BMP_H-1:0]     BITMAP     = LOGO_BITMAP,
    parameter int unsigned                SCALE_LOG2 = 3,
    parameter int unsigned                ORIGIN_X   = 11,
    parameter int unsigned                ORIGIN_Y   = 38,
    parameter int unsigned                WINDOW_W   = 40,
    parameter int unsigned                SCROLL_DIV = 2,
    parameter int unsigned                BLINK_DIV  = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic       i_frame_start,
    input  logic       i_enable,
    input  logic [1:0] i_mode,
    output logic       o_overlay_active
);

    localparam int unsigned PW = clog2_min1(BMP_W);
    localparam int unsigned IW = clog2_min1(BMP_W * BMP_H);

    logic [PW-1:0] w_scroll_pos;
    logic          w_blink_off;

    text_marquee_timer #(
        .BMP_W      (BMP_W),
        .SCROLL_DIV (SCROLL_DIV),
        .BLINK_DIV  (BLINK_DIV)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame_start (i_frame_start),
        .i_enable      (i_enable),
        .i_mode        (i_mode),
        .o_scroll_pos  (w_scroll_pos),
        .o_blink_off   (w_blink_off)
    );

    logic [9:0]    w_cx;
    logic [9:0]    w_cy;
    logic          w_in_range;
    logic          w_scroll_mode;
    logic          w_blink_mode;
    logic [10:0]   w_col_sum;
    logic [10:0]   w_col;
    logic [IW-1:0] w_idx;
    logic          w_pixel;
    logic          r_overlay_active;

    // Modulo-1024 subtraction: anything left of/above the origin wraps high and
    // fails the range check below.
    assign w_cx = (i_x >> SCALE_LOG2) - 10'(ORIGIN_X);
    assign w_cy = (i_y >> SCALE_LOG2) - 10'(ORIGIN_Y);

    assign w_in_range = (w_cy < 10'(BMP_H)) && (w_cx < 10'(WINDOW_W));

    assign w_scroll_mode = (i_mode == MODE_SCROLL) || (i_mode == MODE_SCROLL_BLINK);
    assign w_blink_mode  = (i_mode == MODE_BLINK)  || (i_mode == MODE_SCROLL_BLINK);

    // cx < WINDOW_W <= BMP_W and scroll_pos < BMP_W, so one subtract wraps it.
    assign w_col_sum = {1'b0, w_cx} + 11'(w_scroll_pos);

    always_comb begin
        w_col = {1'b0, w_cx};
        if (w_scroll_mode) begin
            w_col = (w_col_sum >= 11'(BMP_W)) ? (w_col_sum - 11'(BMP_W)) : w_col_sum;
        end
    end

    // Index forced to 0 when out of range so the lookup never leaves the bitmap.
    assign w_idx = w_in_range ? IW'(20'(w_cy) * 20'(BMP_W) + 20'(w_col)) : '0;

    assign w_pixel = w_in_range && BITMAP[w_idx] && !(w_blink_mode && w_blink_off);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overlay_active <= 1'b0;
        end else begin
            r_overlay_active <= i_enable && w_pixel;
        end
    end

    assign o_overlay_active = r_overlay_active;

endmodule

// File: tb/tb_text_marquee.sv
module tb_text_marquee;

    localparam int unsigned BMP_W = 8;
    localparam int unsigned BMP_H = 2;
    localparam int unsigned SDIV  = 1;
    localparam int unsigned BDIV  = 2;
    localparam int unsigned WIN_W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       frame_start = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       overlay_active;

    text_marquee #(
        .BMP_W      (BMP_W),
        .BMP_H      (BMP_H),
        .BITMAP     (16'h0081),
        .SCALE_LOG2 (3),
        .ORIGIN_X   (11),
        .ORIGIN_Y   (38),
        .WINDOW_W   (WIN_W),
        .SCROLL_DIV (SDIV),
        .BLINK_DIV  (BDIV)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_x              (x),
        .i_y              (y),
        .i_frame_start    (frame_start),
        .i_enable         (enable),
        .i_mode           (mode),
        .o_overlay_active (overlay_active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard queues, one entry per sampled clock edge.
    bit    exp_q[$];
    string name_q[$];

    // Reference model: frame pulses counted since the last clear.
    logic [15:0] bmp_v = 16'h0081;
    int          n_scroll = 0;
    int          n_blink  = 0;
    bit          rst_drv  = 1'b0;

    function automatic bit model_pixel(input int px, input int py, input logic [1:0] m);
        int cx, cy, col, pos;
        bit off;
        cx  = px / 8 - 11;
        cy  = py / 8 - 38;
        if (cx < 0 || cx >= int'(WIN_W) || cy < 0 || cy >= int'(BMP_H)) return 1'b0;
        pos = (n_scroll / int'(SDIV)) % int'(BMP_W);
        off = ((n_blink / int'(BDIV)) % 2) == 1;
        col = m[0] ? (cx + pos) % int'(BMP_W) : cx;
        if (m[1] && off) return 1'b0;
        return bmp_v[cy * int'(BMP_W) + col];
    endfunction

    task automatic step(input int px, input int py, input bit fs, input bit en,
                        input logic [1:0] m, input string name);
        bit e;
        @(negedge clk);
        rst_n       = rst_drv;
        x           = 10'(px);
        y           = 10'(py);
        frame_start = fs;
        enable      = en;
        mode        = m;
        if (!rst_drv)  e = 1'b0;
        else if (!en)  e = 1'b0;
        else           e = model_pixel(px, py, m);
        exp_q.push_back(e);
        name_q.push_back(name);
        if (!rst_drv || !en) begin
            n_scroll = 0;
            n_blink  = 0;
        end else if (fs) begin
            if (m[0]) n_scroll++;
            if (m[1]) n_blink++;
        end
    endtask

    // Monitor: output is presented every cycle, compared just after each edge.
    initial begin
        bit    e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                total++;
                if (overlay_active !== e) begin
                    bad++;
                    $display("FAIL %s: got %0b expected %0b (x=%0d y=%0d mode=%0b)",
                             n, overlay_active, e, x, y, mode);
                end
            end
        end
    end

    initial begin
        // Reset
        rst_drv = 1'b0;
        step(88, 304, 0, 1, 2'b00, "reset_hold");
        step(88, 304, 0, 1, 2'b00, "reset_hold");
        rst_drv = 1'b1;
        step(88, 304, 0, 1, 2'b00, "reset_release");

        // Static bounds
        step(87,  304, 0, 1, 2'b00, "static_x87");
        step(88,  304, 0, 1, 2'b00, "static_x88");
        step(95,  304, 0, 1, 2'b00, "static_x95");
        step(96,  304, 0, 1, 2'b00, "static_x96");
        step(144, 304, 0, 1, 2'b00, "static_col7");
        step(152, 304, 0, 1, 2'b00, "static_outside_window");
        step(0,   304, 0, 1, 2'b00, "static_wrap_x0");
        step(88,  303, 0, 1, 2'b00, "static_y303");
        step(88,  320, 0, 1, 2'b00, "static_row2");
        step(144, 312, 0, 1, 2'b00, "static_row1");

        // Scroll: pulse coincident with a pixel uses the old position
        step(88,  304, 1, 1, 2'b01, "scroll_pulse1");
        step(88,  304, 0, 1, 2'b01, "scroll_pos1_x88");
        step(136, 304, 0, 1, 2'b01, "scroll_pos1_x136");
        for (int i = 0; i < 7; i++) step(88, 304, 1, 1, 2'b01, "scroll_pulses");
        step(88,  304, 0, 1, 2'b01, "scroll_wrap");

        // Blink
        step(88, 304, 0, 0, 2'b10, "clear");
        for (int i = 0; i < 4; i++) begin
            step(88, 304, 1, 1, 2'b10, "blink_pulse");
            step(88, 304, 0, 1, 2'b10, "blink_after_pulse");
        end

        // Scroll + blink
        step(88, 304, 0, 0, 2'b11, "clear");
        for (int i = 0; i < 6; i++) begin
            step(88,  304, 1, 1, 2'b11, "both_pulse");
            step(88,  304, 0, 1, 2'b11, "both_x88");
            step(136, 304, 0, 1, 2'b11, "both_x136");
        end

        // Simultaneity and enable
        step(88,  304, 0, 0, 2'b01, "clear");
        step(136, 304, 1, 1, 2'b01, "simul_old_pos");
        step(136, 304, 0, 1, 2'b01, "simul_new_pos");
        step(88,  304, 1, 1, 2'b01, "scroll_more");
        step(88,  304, 1, 1, 2'b01, "scroll_more");
        step(88,  304, 1, 0, 2'b01, "enable_low");
        step(88,  304, 0, 1, 2'b01, "enable_cleared_pos");

        // Asynchronous reset mid-scroll at scroll_pos=5
        for (int i = 0; i < 5; i++) step(88, 304, 1, 1, 2'b01, "to_pos5");
        step(104, 304, 0, 1, 2'b01, "pos5_lit");
        @(posedge clk);
        #3;
        rst_n   = 1'b0;
        rst_drv = 1'b0;
        n_scroll = 0;
        n_blink  = 0;
        #1;
        total++;
        if (overlay_active !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got %0b expected 0", overlay_active);
        end
        step(104, 304, 0, 1, 2'b01, "reset_held");
        rst_drv = 1'b1;
        step(88,  304, 0, 1, 2'b01, "after_reset_pos0");

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            int        rx, ry;
            bit        rfs, ren;
            logic [1:0] rm;
            rx  = int'($urandom_range(80, 160));
            ry  = int'($urandom_range(296, 327));
            rfs = ($urandom_range(0, 3) == 0);
            ren = ($urandom_range(0, 19) != 0);
            rm  = 2'($urandom_range(0, 3));
            step(rx, ry, rfs, ren, rm, "random");
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_marquee.md
# text_marquee

Parametrised, registered text overlay for the VGA pixel pipeline. It generalises the fixed single-bitmap overlay: bitmap size, pixel scale and on-screen origin are parameters, and the visible window can scroll horizontally with wrap-around, blink, or both. It sits beside the other overlay generators, is fed the live `x`/`y` pixel counters plus a once-per-frame strobe, and its one-bit `overlay_active` output goes to the colour mux.

## Interface
- `BMP_W`, 60: bitmap width in cells.
- `BMP_H`, 10: bitmap height in cells.
- `BITMAP`, team logo: `BMP_W*BMP_H` bits. Row r, column c is at bit `r*BMP_W + c`; column 0 is leftmost on screen.
- `SCALE_LOG2`, 3: cell size is `2**SCALE_LOG2` pixels square.
- `ORIGIN_X`, 11: left edge, in cells.
- `ORIGIN_Y`, 38: top edge, in cells.
- `WINDOW_W`, 40: visible width in cells. Constraint: `1 <= WINDOW_W <= BMP_W`.
- `SCROLL_DIV`, 2: frames per one-column scroll step (at least 1).
- `BLINK_DIV`, 30: frames per blink half-period (at least 1).
- `clk`, in, 1: pixel clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `x`, in, 10: current pixel column.
- `y`, in, 10: current pixel row.
- `frame_start`, in, 1: single-cycle pulse, once per frame.
- `enable`, in, 1: overlay enable.
- `mode`, in, 2: 00 static, 01 scroll, 10 blink, 11 scroll+blink.
- `overlay_active`, out, 1: registered pixel-on.

## Operation
- Cell coordinates:
  - `cx = (x >> SCALE_LOG2) - ORIGIN_X`, computed modulo 2^10 with no truncation. Left of the origin wraps to a large value and is therefore out of range.
  - `cy` is formed the same way from `y` and `ORIGIN_Y`.
- In range means `cy < BMP_H` and `cx < WINDOW_W`.
- Column select:
  - Static and blink: `col = cx`.
  - Scroll modes: `col = cx + scroll_pos`, minus `BMP_W` if the sum is `>= BMP_W`. A single conditional subtract is enough because `WINDOW_W <= BMP_W`.
- Pixel on = in range AND `BITMAP[cy*BMP_W+col]` AND NOT (blink mode AND `blink_off`).
- State, all updated only on `frame_start` while `enable`=1:
  - `scroll_cnt` counts 0..SCROLL_DIV-1. On wrap, `scroll_pos` increments, modulo `BMP_W`. Both hold when `mode[0]`=0.
  - `blink_cnt` counts 0..BLINK_DIV-1. On wrap, `blink_off` toggles. Both hold when `mode[1]`=0.
- `enable`=0:
  - `overlay_active` is 0 on the next edge.
  - `scroll_cnt`, `scroll_pos`, `blink_cnt` and `blink_off` clear to 0 synchronously.
- Mode change takes effect on the next pixel. Counters are not cleared.

## Timing
- Reset values: `overlay_active`=0, `scroll_pos`=0, `scroll_cnt`=0, `blink_cnt`=0, `blink_off`=0.
- Latency: `overlay_active` at edge N+1 reflects `x`/`y`/`mode`/`enable` sampled at edge N, one cycle. Downstream delays sync by one pixel.
- `frame_start` coincident with a pixel:
  - That pixel uses the pre-update `scroll_pos`/`blink_off`.
  - The new values apply from the following pixel.
- `frame_start` while `enable`=0 is ignored; the clear has priority.
- Reset asserted mid-scroll: all state goes to reset values immediately. After release, the scroll restarts at `scroll_pos`=0.
- `SCROLL_DIV`=1: `scroll_pos` advances on every `frame_start`.

## Structure
- Shared package `text_overlay_pkg` holds:
  - Mode encodings `MODE_STATIC`, `MODE_SCROLL`, `MODE_BLINK`, `MODE_SCROLL_BLINK`.
  - The default logo bitmap constant.
- Sub-module `text_marquee_timer` holds the frame dividers.
  - Inputs: `clk`, `rst_n`, `frame_start`, `enable`, `mode`.
  - Outputs: `scroll_pos`, `blink_off`.
  - Parameters: `BMP_W`, `SCROLL_DIV`, `BLINK_DIV`.
- The top level does the coordinate math, column select, bitmap lookup and output register.

## Test plan
Bench parameters: `BMP_W`=8, `BMP_H`=2, `BITMAP`=16'h0081 (row 0, columns 0 and 7 lit), `WINDOW_W`=8, `SCALE_LOG2`=3, origin (11,38), `SCROLL_DIV`=1, `BLINK_DIV`=2.
- **Reset:** `rst_n`=0 with x=88, y=304, mode 00, enable=1 -> `overlay_active`=0. Release reset -> `overlay_active`=1 one cycle after the first sampled edge.
- **Bounds, static:** x=87 -> 0; x=88 and x=95 -> 1; x=96 -> 0; x=144 -> 1 (column 7); x=152 -> 0 (outside window); x=0 -> 0 (wrap); y=303 -> 0; y=320 -> 0 (row 2).
- **Scroll:** mode 01, one `frame_start` -> `scroll_pos`=1. Then x=88 -> 0 and x=136 (cx=6, column 7) -> 1. After 8 pulses total, x=88 -> 1 again (wrap).
- **Blink:**
  - Mode 10: x=88 stays 1 through 2 `frame_start` pulses, is 0 after pulses 2-3, and returns to 1 after pulse 4.
  - Mode 11: both effects compose.
- **Simultaneity and enable:**
  - `frame_start` in the same cycle as x=136 (scroll mode) -> output uses the old `scroll_pos`.
  - `enable`=0 for one cycle mid-scroll -> output 0 next cycle and `scroll_pos` returns to 0.
- **Reset mid-operation:** assert `rst_n` low asynchronously between edges with `scroll_pos`=5 -> output and all state are 0 immediately.
